// File: rtl/picorv32_mem_responder.sv
// Word-addressed SRAM slave for the picorv32 native memory bus with fixed wait-state latency.
// Define PICORV32_MEM_RAND_STALL_EN to add 0..3 LFSR-driven extra wait cycles per request.
module picorv32_mem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return {2'b00, off[31:2]};
  endfunction

  function automatic logic out_of_range(input logic [31:0] idx);
    return idx >= MEM_WORDS;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    return res;
  endfunction

  logic [31:0]      mem [0:MEM_WORDS-1];

  state_t           state;
  logic [4:0]       cnt;
  logic [4:0]       load_cnt;

  logic [IDX_W-1:0] req_idx_p0;
  logic             req_oor_p0;
  logic [31:0]      req_wdata_p0;
  logic [3:0]       req_wstrb_p0;

  logic [31:0]      live_idx;
  logic             live_oor;
  logic [IDX_W-1:0] rd_sel;
  logic             rd_oor;
  logic             rd_is_read;
  logic             enter_resp;

  logic             unused_instr;
  assign unused_instr = mem_instr;

  assign live_idx = word_index(mem_addr);
  assign live_oor = out_of_range(live_idx);

`ifdef PICORV32_MEM_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; free-running so the stall pattern is fixed from reset.
  always_ff @(posedge clk) begin
    if (!resetn)
      lfsr <= 16'hACE1;
    else
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign load_cnt = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
`else
  assign load_cnt = 5'(WAIT_CYCLES);
`endif

  // With a zero wait count the response is formed straight from the live bus,
  // otherwise from the fields captured at acceptance.
  always_comb begin
    rd_sel     = req_idx_p0;
    rd_oor     = req_oor_p0;
    rd_is_read = (req_wstrb_p0 == 4'b0000);
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        rd_sel     = live_idx[IDX_W-1:0];
        rd_oor     = live_oor;
        rd_is_read = (mem_wstrb == 4'b0000);
        enter_resp = mem_valid && (load_cnt == 5'd0);
      end
      WAIT: enter_resp = mem_valid && (cnt <= 5'd1);
      default: enter_resp = 1'b0;
    endcase
  end

  // Stage p0: request capture on acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && mem_valid) begin
      req_idx_p0   <= live_idx[IDX_W-1:0];
      req_oor_p0   <= live_oor;
      req_wdata_p0 <= mem_wdata;
      req_wstrb_p0 <= mem_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      err       <= 1'b0;
    end else begin
      mem_ready <= enter_resp;
      err       <= enter_resp && rd_oor;
      if (enter_resp) begin
        if (rd_oor)
          mem_rdata <= 32'h0;
        else if (rd_is_read)
          mem_rdata <= mem[rd_sel];
      end
      case (state)
        IDLE: begin
          if (mem_valid) begin
            cnt   <= load_cnt;
            state <= (load_cnt == 5'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!mem_valid)
            state <= IDLE;
          else if (cnt <= 5'd1)
            state <= RESP;
          else
            cnt <= cnt - 5'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: array commit at the end of the response cycle; reset drops it
  always_ff @(posedge clk) begin
    if (resetn && state == RESP && !req_oor_p0 && req_wstrb_p0 != 4'b0000)
      mem[req_idx_p0] <= byte_merge(mem[req_idx_p0], req_wdata_p0, req_wstrb_p0);
  end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Randomized bench for picorv32_mem_responder against a transaction-level memory model.
// Compile with PICORV32_MEM_RAND_STALL_EN to exercise the randomized stall latency.
module tb_picorv32_mem_responder;

  localparam int unsigned MW = 1024;
  localparam int unsigned WC = 2;
  localparam logic [31:0] AB = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        err;

  picorv32_mem_responder #(
    .MEM_WORDS  (MW),
    .WAIT_CYCLES(WC),
    .ADDR_BASE  (AB)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Model memory: only words whose full content is known are present.
  logic [31:0] mm [int unsigned];

  bit          chk_on = 1'b0;
  int          exp_cyc = -1;
  int          issue_cyc = 0;
  int          last_ready_cyc = 0;
  bit          exp_err, exp_read, exp_known;
  logic [31:0] exp_rdata;
  logic [31:0] cur_idx, cur_wd;
  logic [3:0]  cur_ws;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      bit hit;
      hit = (cyc == exp_cyc);
      chk("mem_ready", {31'b0, mem_ready}, {31'b0, hit});
      chk("err", {31'b0, err}, {31'b0, hit && exp_err});
      if (hit && exp_read && exp_known) chk("mem_rdata", mem_rdata, exp_rdata);
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int extra;
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    cur_idx   = (a - AB) >> 2;
    cur_wd    = wd;
    cur_ws    = ws;
    issue_cyc = cyc;
    exp_err   = (cur_idx >= MW);
    exp_read  = (ws == 4'h0);
    exp_known = exp_err || mm.exists(cur_idx);
    exp_rdata = (!exp_err && mm.exists(cur_idx)) ? mm[cur_idx] : 32'h0;
    extra = 0;
`ifdef PICORV32_MEM_RAND_STALL_EN
    extra = int'(m_lfsr[1:0]);
`endif
    exp_cyc = cyc + 1 + int'(WC) + extra;
  endtask

  task automatic finish_req(input bit hold, input bit scramble, output int lat,
                            output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    lat = -1;
    rd = 32'h0;
    er = 1'b0;
    while (1) begin
      @(negedge clk);
      if (mem_ready) break;
      n++;
      if (n > 40) begin
        chk("ready_timeout", {31'b0, mem_ready}, 32'h1);
        break;
      end
      if (scramble && cyc > issue_cyc) begin
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom_range(0, 15));
      end
    end
    if (mem_ready) begin
      lat = cyc - issue_cyc;
      last_ready_cyc = cyc;
      rd = mem_rdata;
      er = err;
      if (!exp_err && cur_ws != 4'h0) begin
        if (mm.exists(cur_idx)) begin
          logic [31:0] w;
          w = mm[cur_idx];
          for (int b = 0; b < 4; b++) if (cur_ws[b]) w[b*8 +: 8] = cur_wd[b*8 +: 8];
          mm[cur_idx] = w;
        end else if (cur_ws == 4'hF) begin
          mm[cur_idx] = cur_wd;
        end
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input bit hold, output int lat, output logic [31:0] rd, output logic er);
    issue(a, wd, ws);
    finish_req(hold, 1'b0, lat, rd, er);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    mem_valid = 1'b0;
    exp_cyc = -1;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          lat, r1;
    logic [31:0] rd;
    logic        er;
    int          lats_a [16];
    int          lats_b [16];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'b0, mem_ready}, 32'h0);
    chk("reset_rdata", mem_rdata, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    chk_on = 1'b1;

    // Full write then read back
    req(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, rd, er);
`ifndef PICORV32_MEM_RAND_STALL_EN
    chk("t1_write_latency", lat, 32'd3);
`endif
    chk("t1_write_err", {31'b0, er}, 32'h0);
    req(32'h10, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t1_read_data", rd, 32'hDEADBEEF);

    // Byte-lane writes
    req(32'h10, 32'h0000_5500, 4'b0010, 1'b0, lat, rd, er);
    req(32'h10, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t2_lane1", rd, 32'hDEAD55EF);
    req(32'h10, 32'h1200_0000, 4'b1000, 1'b0, lat, rd, er);
    req(32'h10, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t2_lane3", rd, 32'h12AD55EF);

    // Out of range
    req(32'h0, 32'hCAFEF00D, 4'hF, 1'b0, lat, rd, er);
    req(AB + 4 * MW, 32'h0, 4'h0, 1'b0, lat, rd, er);
`ifndef PICORV32_MEM_RAND_STALL_EN
    chk("t3_oor_latency", lat, 32'd3);
`endif
    chk("t3_oor_err", {31'b0, er}, 32'h1);
    chk("t3_oor_rdata", rd, 32'h0);
    req(AB + 4 * MW, 32'hFFFF_FFFF, 4'hF, 1'b0, lat, rd, er);
    chk("t3_oor_werr", {31'b0, er}, 32'h1);
    req(32'h0, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t3_word0_kept", rd, 32'hCAFEF00D);

    // Back-to-back reads with mem_valid held
    req(32'h4, 32'h0BADC0DE, 4'hF, 1'b0, lat, rd, er);
    req(32'h0, 32'h0, 4'h0, 1'b1, lat, rd, er);
    chk("t4_first_data", rd, 32'hCAFEF00D);
    r1 = last_ready_cyc;
    req(32'h4, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t4_second_data", rd, 32'h0BADC0DE);
`ifndef PICORV32_MEM_RAND_STALL_EN
    chk("t4_spacing", last_ready_cyc - r1, 32'd4);
`endif

    // Reset during WAIT discards the write
    req(32'h20, 32'h11223344, 4'hF, 1'b0, lat, rd, er);
    issue(32'h20, 32'hA5A5A5A5, 4'hF);
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_cyc = -1;
    @(posedge clk); #1;
    resetn = 1'b1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("t5_reset_rdata", mem_rdata, 32'h0);
    repeat (6) @(posedge clk);
    req(32'h20, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t5_prewrite_value", rd, 32'h11223344);

    // mem_valid dropped during WAIT aborts the write
    issue(32'h20, 32'h55555555, 4'hF);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    exp_cyc = -1;
    repeat (6) @(posedge clk);
    req(32'h20, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t5_abort_value", rd, 32'h11223344);

    // Randomized traffic, including bus changes during WAIT
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [3:0]  ws;
      int          r;
      r = $urandom_range(0, 9);
      if (r < 8)       a = AB + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else if (r == 8) a = AB + 32'(4 * MW) + 32'(4 * $urandom_range(0, 7));
      else             a = AB - 32'(4 * $urandom_range(1, 4));
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      issue(a, $urandom, ws);
      finish_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat, rd, er);
    end

`ifdef PICORV32_MEM_RAND_STALL_EN
    begin
      int distinct;
      do_reset();
      for (int i = 0; i < 16; i++) begin
        req(32'h0, 32'h0, 4'h0, 1'b0, lat, rd, er);
        lats_a[i] = lat;
        chk("t6_latency_range", {31'b0, (lat >= 3 && lat <= 6)}, 32'h1);
      end
      distinct = 0;
      for (int i = 1; i < 16; i++) if (lats_a[i] != lats_a[0]) distinct = 1;
      chk("t6_latency_varies", distinct, 32'd1);
      do_reset();
      for (int i = 0; i < 16; i++) begin
        req(32'h0, 32'h0, 4'h0, 1'b0, lat, rd, er);
        lats_b[i] = lat;
        chk("t6_repeatable", lats_b[i], lats_a[i]);
      end
    end
`else
    lats_a[0] = 0;
    lats_b[0] = lats_a[0];
`endif

    repeat (4) @(posedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
